// File: rtl/pygmy_intf_typedef.sv
// Shared ring interface types: station id width, response payloads and
// the helper that extracts a response's destination station id.
package pygmy_intf_typedef;

    localparam int RING_STATION_ID_WIDTH = 4;
    localparam int RESP_ID_WIDTH = 8;
    localparam int RESP_DATA_WIDTH = 64;

    typedef logic [RESP_ID_WIDTH-1:0] oursring_resp_id_t;

    typedef struct packed {
        oursring_resp_id_t bid;
        logic [1:0]        bresp;
    } oursring_resp_if_b_t;

    typedef struct packed {
        oursring_resp_id_t          rid;
        logic [RESP_DATA_WIDTH-1:0] rdata;
        logic [1:0]                 rresp;
        logic                       rlast;
    } oursring_resp_if_r_t;

    // The destination station sits in the upper bits of the response id.
    function automatic logic [RING_STATION_ID_WIDTH-1:0] resp_dst_station(
        input oursring_resp_id_t id
    );
        return id[RESP_ID_WIDTH-1 -: RING_STATION_ID_WIDTH];
    endfunction

endpackage

// File: rtl/oursring_resp_route_if.sv
// B/R response bundle for N ring ports.
// master drives payload and valid, slave drives ready.
interface oursring_resp_route_if #(
    parameter int N = 3
);
    import pygmy_intf_typedef::*;

    oursring_resp_if_b_t [N-1:0] b;
    logic [N-1:0]                bvalid;
    logic [N-1:0]                bready;
    oursring_resp_if_r_t [N-1:0] r;
    logic [N-1:0]                rvalid;
    logic [N-1:0]                rready;

    modport master (
        output b, bvalid, r, rvalid,
        input  bready, rready
    );

    modport slave (
        input  b, bvalid, r, rvalid,
        output bready, rready
    );

endinterface

// File: rtl/oursring_resp_route_buf.sv
// One response channel: 2-entry skid FIFO that decodes the destination
// at enqueue, stores a one-hot match, and silently drops unroutable beats.
module oursring_resp_route_buf
    import pygmy_intf_typedef::*;
#(
    parameter type T     = oursring_resp_if_b_t,
    parameter int  N_OUT = 3,
    parameter int  SW    = RING_STATION_ID_WIDTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [N_OUT-1:0][SW-1:0] station_id,
    input  T                         in_data,
    input  logic [SW-1:0]            in_dst,
    input  logic                     in_valid,
    output logic                     in_ready,
    output T                         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_OUT-1:0]         out_match,
    output logic                     drop
);

    T                 mem [2];
    logic [N_OUT-1:0] mat [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic [1:0]       cnt_nxt;
    logic             rdy_q;
    logic [N_OUT-1:0] hit;
    logic [N_OUT-1:0] hit_1h;
    logic [N_OUT-1:0] head_match;
    logic             nonempty;
    logic             enq;
    logic             deq;

    always_comb begin
        hit = '0;
        for (int j = 0; j < N_OUT; j++) begin
            hit[j] = (in_dst == station_id[j]);
        end
    end

    // Isolate the lowest set bit so duplicate station ids route to one output.
    assign hit_1h = hit & (~hit + N_OUT'(1));

    assign nonempty   = (cnt != 2'd0);
    assign head_match = mat[rd_ptr];
    assign out_valid  = nonempty && (head_match != '0);
    assign drop       = nonempty && (head_match == '0);
    assign out_data   = mem[rd_ptr];
    assign out_match  = out_valid ? head_match : '0;

    assign in_ready = rdy_q && rstn;
    assign enq      = in_valid && in_ready;
    assign deq      = (out_valid && out_ready) || drop;

    always_comb begin
        cnt_nxt = cnt;
        unique case (1'b1)
            enq && !deq: cnt_nxt = cnt + 2'd1;
            deq && !enq: cnt_nxt = cnt - 2'd1;
            default:     cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            rdy_q  <= 1'b1;
            mat[0] <= '0;
            mat[1] <= '0;
        end else begin
            cnt   <= cnt_nxt;
            rdy_q <= (cnt_nxt != 2'd2);
            if (enq) begin
                wr_ptr      <= ~wr_ptr;
                mat[wr_ptr] <= hit_1h;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: rtl/oursring_resp_route.sv
// Ingress routing stage ahead of the oursring response crossbar.
// Optional per-input drop counters: define OURSRING_RESP_ROUTE_ERR_CNT_EN.
module oursring_resp_route
    import pygmy_intf_typedef::*;
#(
    parameter int N_IN_PORT    = 3,
    parameter int N_OUT_PORT   = 3,
    parameter int STATION_ID_W = RING_STATION_ID_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic [N_OUT_PORT-1:0][STATION_ID_W-1:0]  i_out_station_id,
    oursring_resp_route_if.slave                     i_resp_if,
    oursring_resp_route_if.master                    o_resp_if,
    output logic [N_IN_PORT-1:0][N_OUT_PORT-1:0]     o_is_b_dst_match,
    output logic [N_IN_PORT-1:0][N_OUT_PORT-1:0]     o_is_r_dst_match
`ifdef OURSRING_RESP_ROUTE_ERR_CNT_EN
    ,
    output logic [N_IN_PORT-1:0][7:0]                o_drop_cnt,
    output logic                                     o_drop_err
`endif
);

    oursring_resp_if_b_t [N_IN_PORT-1:0] b_out;
    oursring_resp_if_r_t [N_IN_PORT-1:0] r_out;
    logic [N_IN_PORT-1:0] b_valid;
    logic [N_IN_PORT-1:0] r_valid;
    logic [N_IN_PORT-1:0] b_ready;
    logic [N_IN_PORT-1:0] r_ready;
    logic [N_IN_PORT-1:0] b_drop;
    logic [N_IN_PORT-1:0] r_drop;

    for (genvar p = 0; p < N_IN_PORT; p++) begin : g_port
        logic [STATION_ID_W-1:0] b_dst;
        logic [STATION_ID_W-1:0] r_dst;

        assign b_dst = STATION_ID_W'(resp_dst_station(i_resp_if.b[p].bid));
        assign r_dst = STATION_ID_W'(resp_dst_station(i_resp_if.r[p].rid));

        oursring_resp_route_buf #(
            .T     (oursring_resp_if_b_t),
            .N_OUT (N_OUT_PORT),
            .SW    (STATION_ID_W)
        ) u_b (
            .clk        (clk),
            .rstn       (rstn),
            .station_id (i_out_station_id),
            .in_data    (i_resp_if.b[p]),
            .in_dst     (b_dst),
            .in_valid   (i_resp_if.bvalid[p]),
            .in_ready   (b_ready[p]),
            .out_data   (b_out[p]),
            .out_valid  (b_valid[p]),
            .out_ready  (o_resp_if.bready[p]),
            .out_match  (o_is_b_dst_match[p]),
            .drop       (b_drop[p])
        );

        oursring_resp_route_buf #(
            .T     (oursring_resp_if_r_t),
            .N_OUT (N_OUT_PORT),
            .SW    (STATION_ID_W)
        ) u_r (
            .clk        (clk),
            .rstn       (rstn),
            .station_id (i_out_station_id),
            .in_data    (i_resp_if.r[p]),
            .in_dst     (r_dst),
            .in_valid   (i_resp_if.rvalid[p]),
            .in_ready   (r_ready[p]),
            .out_data   (r_out[p]),
            .out_valid  (r_valid[p]),
            .out_ready  (o_resp_if.rready[p]),
            .out_match  (o_is_r_dst_match[p]),
            .drop       (r_drop[p])
        );
    end

    assign i_resp_if.bready = b_ready;
    assign i_resp_if.rready = r_ready;
    assign o_resp_if.b      = b_out;
    assign o_resp_if.r      = r_out;
    assign o_resp_if.bvalid = b_valid;
    assign o_resp_if.rvalid = r_valid;

`ifdef OURSRING_RESP_ROUTE_ERR_CNT_EN
    logic [N_IN_PORT-1:0][7:0] drop_cnt;
    logic                      drop_err;

    // B and R drops of one input share a counter that saturates at 255.
    function automatic logic [7:0] drop_sat(
        input logic [7:0] c,
        input logic       a,
        input logic       b
    );
        logic [8:0] sum;
        sum = {1'b0, c} + {8'd0, a} + {8'd0, b};
        return sum[8] ? 8'hff : sum[7:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            drop_cnt <= '0;
            drop_err <= 1'b0;
        end else begin
            for (int p = 0; p < N_IN_PORT; p++) begin
                drop_cnt[p] <= drop_sat(drop_cnt[p], b_drop[p], r_drop[p]);
            end
            drop_err <= drop_err | (|b_drop) | (|r_drop);
        end
    end

    assign o_drop_cnt = drop_cnt;
    assign o_drop_err = drop_err;
`else
    logic unused_drop;
    assign unused_drop = ^{b_drop, r_drop};
`endif

endmodule
